// File: rtl/ethpipe_tx_if.sv
// ethpipe_tx_if
//   Groups every ethpipe_tx signal except the clock and reset.
//   Host side  : tx_req, tx_frame_len, tx_busy, tx_done, tx_err, tx_timestamp
//   Slot RAM   : slot_tx_eth_address (word address), slot_tx_eth_q (data, 1-cycle latency)
//   GMII       : gmii_txd, gmii_tx_en
//   Timebase   : global_counter (free-running, gmii_tx_clk domain)
//   Modports   : master = the transmitter itself, slave = RAM/host/environment side.
interface ethpipe_tx_if;
    logic        tx_req;
    logic [11:0] tx_frame_len;
    logic [63:0] global_counter;
    logic [10:0] slot_tx_eth_address;
    logic [31:0] slot_tx_eth_q;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_err;
    logic [63:0] tx_timestamp;

    modport master (
        input  tx_req, tx_frame_len, global_counter, slot_tx_eth_q,
        output slot_tx_eth_address, gmii_txd, gmii_tx_en,
               tx_busy, tx_done, tx_err, tx_timestamp
    );

    modport slave (
        output tx_req, tx_frame_len, global_counter, slot_tx_eth_q,
        input  slot_tx_eth_address, gmii_txd, gmii_tx_en,
               tx_busy, tx_done, tx_err, tx_timestamp
    );
endinterface

// File: rtl/ethpipe_tx.sv
// ethpipe_tx
//   GMII transmit stage. On a rising tx_req, reads one frame from the TX slot RAM
//   (32-bit words, byte 0 in [7:0], first byte at BASE_ADDR), sends preamble+SFD,
//   the frame bytes, optionally a CRC-32 FCS, then waits IFG_BYTES idle cycles and
//   pulses tx_done (with tx_err when the length was rejected).
// Ports
//   gmii_tx_clk : sole clock (125 MHz)
//   sys_rst     : synchronous active-high reset; aborts a frame in progress
//   bus         : ethpipe_tx_if.master (host handshake, slot RAM, GMII, timestamp)
// Configuration
//   ETHPIPE_TX_CRC_EN : when defined, a CRC-32 FCS (4 bytes, LSB first) is appended
//                       after the frame bytes. Undefined: host supplies the FCS in len.
//
// state  | meaning
// IDLE   | waiting for an armed tx_req
// PRE    | 7 x 55h then D5h; first word fetched; timestamp taken on D5h
// DATA   | len frame bytes, one per cycle
// CRC    | 4 FCS bytes (ETHPIPE_TX_CRC_EN only)
// IFG    | IFG_BYTES idle cycles
// DONE   | tx_done pulse, address rewound
module ethpipe_tx #(
    parameter logic [10:0] BASE_ADDR     = 11'd2,
    parameter int          IFG_BYTES     = 12,
    parameter logic [11:0] MAX_FRAME_LEN = 12'd1518
) (
    input logic          gmii_tx_clk,
    input logic          sys_rst,
    ethpipe_tx_if.master bus
);

`ifdef ETHPIPE_TX_CRC_EN
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_CRC, S_IFG, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_IFG, S_DONE} state_t;
`endif

    localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);

    state_t      state, state_nxt;
    logic        armed;
    logic [11:0] len_r;
    logic        err_r;
    logic [7:0]  tmr;
    logic [11:0] byte_cnt;
    logic [10:0] addr_r;
    logic [31:0] word_r;
    logic [63:0] ts_r;
    logic [7:0]  txd_c;
    logic        tx_en_c;
    logic        accept;
    logic        len_ok;
    logic        last_byte;

    assign accept    = (state == S_IDLE) && bus.tx_req && armed;
    assign len_ok    = (bus.tx_frame_len != 12'd0) && (bus.tx_frame_len <= MAX_FRAME_LEN);
    assign last_byte = (byte_cnt == len_r - 12'd1);

`ifdef ETHPIPE_TX_CRC_EN
    logic [31:0] crc_r;
    logic [31:0] crc_fin;
    assign crc_fin = ~crc_r;

    // Reflected CRC-32 (poly 04C11DB7h bit-reversed), one byte per call.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        txd_c     = 8'h00;
        tx_en_c   = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nxt = len_ok ? S_PRE : S_IFG;
            S_PRE: begin
                tx_en_c = 1'b1;
                txd_c   = (tmr == 8'd0) ? 8'hD5 : 8'h55;
                if (tmr == 8'd0) state_nxt = S_DATA;
            end
            S_DATA: begin
                tx_en_c = 1'b1;
                txd_c   = 8'(word_r >> {byte_cnt[1:0], 3'b000});
`ifdef ETHPIPE_TX_CRC_EN
                if (last_byte) state_nxt = S_CRC;
`else
                if (last_byte) state_nxt = S_IFG;
`endif
            end
`ifdef ETHPIPE_TX_CRC_EN
            S_CRC: begin
                tx_en_c = 1'b1;
                // tmr runs 3..0, so ~tmr[1:0] gives FCS byte 0..3
                txd_c   = 8'(crc_fin >> {~tmr[1:0], 3'b000});
                if (tmr == 8'd0) state_nxt = S_IFG;
            end
`endif
            S_IFG:   if (tmr == 8'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            armed    <= 1'b0;
            len_r    <= 12'd0;
            err_r    <= 1'b0;
            tmr      <= 8'd0;
            byte_cnt <= 12'd0;
            addr_r   <= BASE_ADDR;
            word_r   <= 32'd0;
            ts_r     <= 64'd0;
`ifdef ETHPIPE_TX_CRC_EN
            crc_r    <= 32'hFFFFFFFF;
`endif
        end else begin
            // A new frame needs tx_req to have been low since the last completion.
            if (state == S_DONE)  armed <= 1'b0;
            else if (!bus.tx_req) armed <= 1'b1;

            case (state)
                S_IDLE: if (accept) begin
                    len_r  <= bus.tx_frame_len;
                    err_r  <= !len_ok;
                    tmr    <= len_ok ? 8'd7 : IFG_LOAD;
                    addr_r <= BASE_ADDR;
                end
                S_PRE: begin
                    tmr <= tmr - 8'd1;
                    if (tmr == 8'd0) begin
                        ts_r     <= bus.global_counter;
                        word_r   <= bus.slot_tx_eth_q;
                        addr_r   <= addr_r + 11'd1;
                        byte_cnt <= 12'd0;
`ifdef ETHPIPE_TX_CRC_EN
                        crc_r    <= 32'hFFFFFFFF;
`endif
                    end
                end
                S_DATA: begin
                    byte_cnt <= byte_cnt + 12'd1;
`ifdef ETHPIPE_TX_CRC_EN
                    crc_r    <= crc_step(crc_r, txd_c);
`endif
                    // Next word was addressed at the start of this word, so it is already valid.
                    if (byte_cnt[1:0] == 2'd3) begin
                        word_r <= bus.slot_tx_eth_q;
                        addr_r <= addr_r + 11'd1;
                    end
`ifdef ETHPIPE_TX_CRC_EN
                    if (last_byte) tmr <= 8'd3;
`else
                    if (last_byte) tmr <= IFG_LOAD;
`endif
                end
`ifdef ETHPIPE_TX_CRC_EN
                S_CRC: tmr <= (tmr == 8'd0) ? IFG_LOAD : tmr - 8'd1;
`endif
                S_IFG:   tmr <= tmr - 8'd1;
                S_DONE:  addr_r <= BASE_ADDR;
                default: ;
            endcase
        end
    end

    assign bus.gmii_txd            = txd_c;
    assign bus.gmii_tx_en          = tx_en_c;
    assign bus.slot_tx_eth_address = addr_r;
    assign bus.tx_busy             = (state != S_IDLE) && (state != S_DONE);
    assign bus.tx_done             = (state == S_DONE);
    assign bus.tx_err              = (state == S_DONE) && err_r;
    assign bus.tx_timestamp        = ts_r;

endmodule
